// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between the register-file read stage, the ALU issue stage
// and the EX stage. The master drives instructions in and accepts issued results.
interface alu_issue_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_alu_a;
   logic [XLEN-1:0] out_alu_b;
   logic [3:0]      out_alu_sel;
   logic [4:0]      out_rd;
   logic            out_reg_wen;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   modport master (
      output flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
      input  in_ready, out_valid, out_alu_a, out_alu_b, out_alu_sel, out_rd, out_reg_wen,
             out_pc, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
      output in_ready, out_valid, out_alu_a, out_alu_b, out_alu_sel, out_rd, out_reg_wen,
             out_pc, out_illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ID/EX issue register: decodes ALU select and operands into a one-entry ready/valid
// stage. Define ALU_ISSUE_ILLEGAL_EN to flag and neutralise undecodable instructions.
module alu_issue_stage #(
   parameter int unsigned    XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
   input logic               clock,
   input logic               reset_n,
   alu_issue_stage_if.slave  bus
);
   typedef enum logic [3:0] {
      SelAdd  = 4'd0,
      SelSub  = 4'd1,
      SelAnd  = 4'd2,
      SelOr   = 4'd3,
      SelXor  = 4'd4,
      SelSll  = 4'd5,
      SelSrl  = 4'd6,
      SelSra  = 4'd7,
      SelSlt  = 4'd8,
      SelSltu = 4'd9,
      SelLui  = 4'd10,
      SelJadd = 4'd11
   } alu_sel_e;

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   // alt picks SUB over ADD and SRA over SRL; callers gate it per opcode
   function automatic alu_sel_e funct3_sel(input logic [2:0] f3, input logic alt);
      unique case (f3)
         3'b000:  funct3_sel = alt ? SelSub : SelAdd;
         3'b001:  funct3_sel = SelSll;
         3'b010:  funct3_sel = SelSlt;
         3'b011:  funct3_sel = SelSltu;
         3'b100:  funct3_sel = SelXor;
         3'b101:  funct3_sel = alt ? SelSra : SelSrl;
         3'b110:  funct3_sel = SelOr;
         default: funct3_sel = SelAnd;
      endcase
   endfunction

   logic [31:0]     inst;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic            f7_ok;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign inst   = bus.in_inst;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign rd     = inst[11:7];
   assign f7_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

   logic [XLEN-1:0] dec_a, dec_b;
   alu_sel_e        dec_sel;
   logic            dec_wen;
   logic            dec_ill;

   always_comb begin
      dec_a   = bus.in_rs1;
      dec_b   = bus.in_rs2;
      dec_sel = SelAdd;
      dec_wen = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         OpcOp: begin
            dec_sel = funct3_sel(funct3, inst[30]);
            dec_wen = 1'b1;
            dec_ill = !f7_ok ||
                      (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101);
         end
         OpcOpImm: begin
            dec_sel = funct3_sel(funct3, inst[30] && funct3 == 3'b101);
            dec_b   = imm_i;
            dec_wen = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_b = {27'b0, inst[24:20]};
            end
            dec_ill = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && !f7_ok);
         end
         OpcLui: begin
            dec_a   = '0;
            dec_b   = imm_u;
            dec_sel = SelLui;
            dec_wen = 1'b1;
         end
         OpcAuipc: begin
            dec_a   = bus.in_pc;
            dec_b   = imm_u;
            dec_wen = 1'b1;
         end
         OpcJal: begin
            dec_a   = bus.in_pc;
            dec_b   = imm_j;
            dec_wen = 1'b1;
         end
         OpcJalr: begin
            dec_b   = imm_i;
            dec_sel = SelJadd;
            dec_wen = 1'b1;
         end
         OpcLoad: begin
            dec_b   = imm_i;
            dec_wen = 1'b1;
         end
         OpcStore: dec_b = imm_s;
         OpcBranch: begin
            dec_a = bus.in_pc;
            dec_b = imm_b;
         end
         default: dec_ill = 1'b1;
      endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
      if (dec_ill) begin
         dec_a   = '0;
         dec_b   = '0;
         dec_sel = SelAdd;
         dec_wen = 1'b0;
      end
`endif
      if (rd == 5'd0) begin
         dec_wen = 1'b0;
      end
   end

   logic            valid_q;
   logic [XLEN-1:0] alu_a_q, alu_b_q, pc_q;
   alu_sel_e        alu_sel_q;
   logic [4:0]      rd_q;
   logic            wen_q;
   logic            load;

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign load         = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= SelAdd;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         pc_q      <= RESET_PC_TAG;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q   <= 1'b1;
         alu_a_q   <= dec_a;
         alu_b_q   <= dec_b;
         alu_sel_q <= dec_sel;
         rd_q      <= rd;
         wen_q     <= dec_wen;
         pc_q      <= bus.in_pc;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

`ifdef ALU_ISSUE_ILLEGAL_EN
   logic illegal_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         illegal_q <= 1'b0;
      end else if (!bus.flush && load) begin
         illegal_q <= dec_ill;
      end
   end

   assign bus.out_illegal = illegal_q;
`else
   logic unused_ill;
   assign unused_ill      = dec_ill;
   assign bus.out_illegal = 1'b0;
`endif

   assign bus.out_valid   = valid_q;
   assign bus.out_alu_a   = alu_a_q;
   assign bus.out_alu_b   = alu_b_q;
   assign bus.out_alu_sel = alu_sel_q;
   assign bus.out_rd      = rd_q;
   assign bus.out_reg_wen = wen_q;
   assign bus.out_pc      = pc_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic against a
// mnemonic-level reference model of the issue register.
module tb_alu_issue_stage;
   localparam logic [31:0] RstPc = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
      logic [31:0] pc;
   } issue_t;

   // base select per funct3: ADD SLL SLT SLTU XOR SRL OR AND
   localparam int unsigned BaseSel [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
   localparam logic [6:0]  LegalOpc [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                            7'h03, 7'h23, 7'h63};

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   alu_issue_stage_if #(.XLEN(32)) bus ();

   alu_issue_stage #(.XLEN(32), .RESET_PC_TAG(RstPc)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic        exp_valid = 1'b0;
   issue_t      exp_q;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic issue_t reset_state();
      issue_t r;
      r    = '0;
      r.pc = RstPc;
      return r;
   endfunction

   function automatic issue_t ref_issue(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
      issue_t      r;
      int unsigned f3, f7;
      logic        alt, bad;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      f3    = 32'(inst[14:12]);
      f7    = 32'(inst[31:25]);
      alt   = inst[30];
      bad   = 1'b0;
      imm_i = 32'($signed(inst) >>> 20);
      imm_s = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
      imm_b = (32'($signed(inst) >>> 31) << 12) | (32'(inst[7]) << 11) |
              (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      imm_u = inst & 32'hFFFF_F000;
      imm_j = (32'($signed(inst) >>> 31) << 20) | (32'(inst[19:12]) << 12) |
              (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      r    = '0;
      r.pc = pc;
      r.rd = inst[11:7];
      case (inst[6:0])
         7'h33: begin
            r.a   = rs1;
            r.b   = rs2;
            r.sel = 4'(BaseSel[f3] + ((alt && (f3 == 0 || f3 == 5)) ? 1 : 0));
            r.wen = 1'b1;
            bad   = !(f7 == 0 || f7 == 32) || (f7 == 32 && !(f3 == 0 || f3 == 5));
         end
         7'h13: begin
            r.a   = rs1;
            r.b   = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : imm_i;
            r.sel = 4'(BaseSel[f3] + ((alt && f3 == 5) ? 1 : 0));
            r.wen = 1'b1;
            bad   = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
         end
         7'h37: begin r.a = 0;   r.b = imm_u; r.sel = 10; r.wen = 1'b1; end
         7'h17: begin r.a = pc;  r.b = imm_u; r.sel = 0;  r.wen = 1'b1; end
         7'h6F: begin r.a = pc;  r.b = imm_j; r.sel = 0;  r.wen = 1'b1; end
         7'h67: begin r.a = rs1; r.b = imm_i; r.sel = 11; r.wen = 1'b1; end
         7'h03: begin r.a = rs1; r.b = imm_i; r.sel = 0;  r.wen = 1'b1; end
         7'h23: begin r.a = rs1; r.b = imm_s; r.sel = 0;  r.wen = 1'b0; end
         7'h63: begin r.a = pc;  r.b = imm_b; r.sel = 0;  r.wen = 1'b0; end
         default: begin r.a = rs1; r.b = rs2; r.sel = 0; r.wen = 1'b0; bad = 1'b1; end
      endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
      if (bad) begin
         r.ill = 1'b1;
         r.a   = 0;
         r.b   = 0;
         r.sel = 0;
         r.wen = 1'b0;
      end
`else
      if (bad) r.ill = 1'b0;
`endif
      if (r.rd == 0) r.wen = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] inst;
      int unsigned pick, f7pick;
      inst   = $urandom;
      pick   = $urandom_range(0, 9);
      f7pick = $urandom_range(0, 3);
      inst[6:0] = (pick == 9) ? 7'($urandom) : LegalOpc[pick];
      if (f7pick == 0) inst[31:25] = 7'h00;
      else if (f7pick == 1) inst[31:25] = 7'h20;
      return inst;
   endfunction

   task automatic check_outputs();
      check_eq("out_valid", bus.out_valid, exp_valid);
      check_eq("out_alu_a", bus.out_alu_a, exp_q.a);
      check_eq("out_alu_b", bus.out_alu_b, exp_q.b);
      check_eq("out_alu_sel", bus.out_alu_sel, exp_q.sel);
      check_eq("out_rd", bus.out_rd, exp_q.rd);
      check_eq("out_reg_wen", bus.out_reg_wen, exp_q.wen);
      check_eq("out_illegal", bus.out_illegal, exp_q.ill);
      check_eq("out_pc", bus.out_pc, exp_q.pc);
   endtask

   // One cycle: check held state, drive inputs on the falling edge, predict the next state.
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic ordy, input logic fl);
      logic rdy;
      @(negedge clock);
      check_outputs();
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.out_ready = ordy;
      bus.flush     = fl;
      #1;
      rdy = !exp_valid || ordy;
      check_eq("in_ready", bus.in_ready, rdy);
      if (fl) begin
         exp_valid = 1'b0;
      end else if (v && rdy) begin
         exp_q     = ref_issue(inst, pc, rs1, rs2);
         exp_valid = 1'b1;
      end else if (ordy) begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic after_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_pc     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.out_ready = 1'b0;
      exp_q         = reset_state();
      #1;
      check_outputs();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // SUB a0,a0,a1
      step(1'b1, 32'h40B5_0533, 32'h100, 32'd10, 32'd3, 1'b1, 1'b0);
      after_edge();
      check_eq("sub_valid", bus.out_valid, 1);
      check_eq("sub_sel", bus.out_alu_sel, 1);
      check_eq("sub_a", bus.out_alu_a, 10);
      check_eq("sub_b", bus.out_alu_b, 3);
      check_eq("sub_rd", bus.out_rd, 10);
      check_eq("sub_wen", bus.out_reg_wen, 1);

      // SRAI a0,a0,4
      step(1'b1, 32'h4045_5513, 32'h104, 32'hF000_0000, 32'd0, 1'b1, 1'b0);
      after_edge();
      check_eq("srai_sel", bus.out_alu_sel, 7);
      check_eq("srai_b", bus.out_alu_b, 4);
      check_eq("srai_wen", bus.out_reg_wen, 1);

      // LUI t0,0x12345
      step(1'b1, 32'h1234_52B7, 32'h108, 32'h5555_5555, 32'd0, 1'b1, 1'b0);
      after_edge();
      check_eq("lui_sel", bus.out_alu_sel, 10);
      check_eq("lui_a", bus.out_alu_a, 0);
      check_eq("lui_b", bus.out_alu_b, 32'h1234_5000);
      check_eq("lui_rd", bus.out_rd, 5);

      // addi x0,x0,5 must not write back
      step(1'b1, 32'h0050_0013, 32'h10C, 32'd0, 32'd0, 1'b1, 1'b0);
      after_edge();
      check_eq("x0_wen", bus.out_reg_wen, 0);

      // unknown opcode still issues
      step(1'b1, 32'h0000_007F, 32'h110, 32'd7, 32'd9, 1'b1, 1'b0);
      after_edge();
      check_eq("ill_valid", bus.out_valid, 1);
      check_eq("ill_wen", bus.out_reg_wen, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      check_eq("ill_flag", bus.out_illegal, 1);
`else
      check_eq("ill_flag", bus.out_illegal, 0);
`endif

      // backpressure: hold for 3 cycles with a new instruction waiting
      step(1'b1, 32'h0020_8193, 32'h200, 32'd1, 32'd0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 32'h0031_0233, 32'h204, 32'd4, 32'd5, 1'b0, 1'b0);
      step(1'b1, 32'h0031_0233, 32'h204, 32'd4, 32'd5, 1'b1, 1'b0);
      after_edge();
      check_eq("bp_next_rd", bus.out_rd, 4);
      check_eq("bp_next_pc", bus.out_pc, 32'h204);
      step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

      // flush kills held and incoming instruction
      step(1'b1, 32'h0010_0093, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 32'h0020_0113, 32'h304, 32'd0, 32'd0, 1'b0, 1'b1);
      after_edge();
      check_eq("flush_valid", bus.out_valid, 0);
      step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end

      // asynchronous reset in the middle of a held instruction
      step(1'b1, 32'h0010_0093, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
      after_edge();
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_valid", bus.out_valid, 0);
      check_eq("rst_sel", bus.out_alu_sel, 0);
      check_eq("rst_pc", bus.out_pc, RstPc);
      exp_valid    = 1'b0;
      exp_q        = reset_state();
      bus.in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
              $urandom_range(0, 2) != 0, 1'b0);
      end
      @(negedge clock);
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue register that drives the ALU. It decodes a 32-bit RV32I instruction into an ALU select code and selects operands (rs1/PC, rs2/immediate).
- It holds the result in a one-entry ready/valid pipeline register.
- Upstream is the register-file read stage. Downstream is the EX stage: ALU plus branch/memory logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, value that out_pc takes at reset.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of held and incoming instruction (branch mispredict)
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_inst  in  32  raw instruction
- in_pc  in  32  instruction PC
- in_rs1  in  32  rs1 register value
- in_rs2  in  32  rs2 register value
- out_valid  out  1  issued instruction valid
- out_ready  in  1  EX stage accepts this cycle
- out_alu_a  out  32  ALU operand A
- out_alu_b  out  32  ALU operand B
- out_alu_sel  out  4  ALU select code
- out_rd  out  5  destination register
- out_reg_wen  out  1  writeback enable
- out_pc  out  32  PC of held instruction
- out_illegal  out  1  undecodable instruction (feature-gated)

Behaviour:
- Reset
  - Asynchronous on reset_n low.
  - out_valid=0, out_alu_a=0, out_alu_b=0, out_alu_sel=ADD, out_rd=0, out_reg_wen=0, out_illegal=0, out_pc=RESET_PC_TAG.
  - Deassertion of reset_n takes effect at the next clock edge.
- ALU select encoding (4 bits):
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, LUIOP=10, JADD=11.
- Handshake
  - in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
  - Load occurs when in_valid && in_ready && !flush. All out_* fields register the decoded values and out_valid becomes 1.
  - If out_valid && out_ready and no new load, out_valid becomes 0 and the data fields hold their old values.
  - If out_valid && !out_ready, every out_* field is held stable.
  - Flush has priority over everything except reset. The next state is out_valid=0 and the incoming instruction is dropped. in_ready is still driven by the formula above.
- Latency: 1 cycle from accepted input to out_valid. Full throughput: one instruction per cycle when out_ready is held high.
- Immediates:
  - I = sext(inst[31:20])
  - S = sext({inst[31:25], inst[11:7]})
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U = {inst[31:12], 12'b0}
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
- Decode by opcode inst[6:0]:
  - 0110011 OP: a=rs1, b=rs2. funct3 000 gives ADD, or SUB when inst[30]=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by inst[30], 110 OR, 111 AND. wen=1.
  - 0010011 OP-IMM: a=rs1, b=I. Same funct3 map, except 000 is always ADD. Shifts use b={27'b0, inst[24:20]}, and SRAI is selected by inst[30]. wen=1.
  - 0110111 LUI: a=0, b=U, LUIOP, wen=1.
  - 0010111 AUIPC: a=pc, b=U, ADD, wen=1.
  - 1101111 JAL: a=pc, b=J, ADD, wen=1.
  - 1100111 JALR: a=rs1, b=I, JADD, wen=1.
  - 0000011 LOAD: a=rs1, b=I, ADD, wen=1.
  - 0100011 STORE: a=rs1, b=S, ADD, wen=0.
  - 1100011 BRANCH: a=pc, b=B, ADD, wen=0.
  - Any other opcode is illegal.
- out_rd = inst[11:7] for all instructions. out_reg_wen is forced to 0 when rd==0.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- Defined:
  - Illegal cases are: unknown opcode; OP with funct7 other than 0000000/0100000; 0100000 with funct3 other than 000/101; OP-IMM SLLI with inst[31:25]≠0; SRLI/SRAI with inst[31:25] other than 0000000/0100000.
  - An illegal instruction registers out_illegal=1, out_reg_wen=0, out_alu_sel=ADD, a=b=0.
  - It still issues with out_valid=1.
- Undefined:
  - out_illegal is tied 0.
  - Unknown opcodes decode as ADD, a=rs1, b=rs2, wen=0. Malformed funct7 values are ignored.

Test Plan:
- Reset:
  - Stimulus: reset_n low mid-stream with out_valid=1.
  - Response: out_valid=0 immediately, before any clock edge; out_alu_sel=0; out_pc=RESET_PC_TAG.
- SUB:
  - Stimulus: inst 0x40B50533 (sub a0,a0,a1), rs1=10, rs2=3, out_ready=1.
  - Response: next cycle out_valid=1, sel=1, a=10, b=3, rd=10, wen=1.
- SRAI:
  - Stimulus: inst 0x40455513 (srai a0,a0,4).
  - Response: sel=7, b=4, wen=1.
  - Stimulus: LUI 0x123452B7.
  - Response: sel=10, a=0, b=0x12345000, rd=5.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1 throughout.
  - Response: in_ready=0 while out_valid=1, all outputs stable. First out_ready=1 cycle retires the held instruction and accepts the next; no drop or duplicate.
- Flush:
  - Stimulus: flush=1 together with in_valid=1 and out_valid=1.
  - Response: next cycle out_valid=0; the incoming instruction never appears.
- Illegal / rd=x0:
  - Stimulus: with ALU_ISSUE_ILLEGAL_EN defined, inst 0x0000007F.
  - Response: out_illegal=1, wen=0, out_valid=1.
  - Stimulus: inst 0x00500013 (addi x0,x0,5).
  - Response: wen=0.
